// File: rtl/wrapper_reg_packet_constructor.sv
// Register-channel responder: gathers 32-bit register writes into one packet and hands it out on valid/ready.
// Optional build macro WRAPPER_PACKET_STROBE_EN enables per-byte write strobes.
//
// state | meaning
// FILL  | collecting words; completes on a write to the top word index
// FULL  | packet presented; held until packet_data_ready, writes stall meanwhile
module wrapper_reg_packet_constructor #(
    parameter int ADDRWIDTH        = 11,
    parameter int PACKETWIDTH      = 512,
    parameter int PACKETSPACEWIDTH = $clog2(PACKETWIDTH / 32)
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [ADDRWIDTH-1:0]   addr,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [3:0]             byte_strobe,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   wready,
    output logic                   rready,
    output logic [PACKETWIDTH-1:0] packet_data,
    output logic                   packet_data_last,
    output logic                   packet_data_valid,
    input  logic                   packet_data_ready
);

    localparam int NUMWORDS = PACKETWIDTH / 32;
    localparam int IDXW     = (PACKETSPACEWIDTH > 0) ? PACKETSPACEWIDTH : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMWORDS - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [NUMWORDS-1:0][31:0]     buf_q, buf_d;
    logic                          last_q, last_d;
    logic [IDXW-1:0]               widx;
    logic                          last_marker;
    logic                          hit_last;
    logic                          unused_ok;

    // A single-word packet has no index bits; every write then targets word 0.
    generate
        if (PACKETSPACEWIDTH > 0) begin : g_idx
            assign widx = addr[PACKETSPACEWIDTH+1:2];
        end else begin : g_idx0
            assign widx = '0;
        end
    endgenerate

    assign last_marker = addr[ADDRWIDTH-1];
    assign hit_last    = (widx == LAST_IDX);
    assign unused_ok   = ^{addr, byte_strobe};

`ifdef WRAPPER_PACKET_STROBE_EN
    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction
`else
    function automatic logic [31:0] merge_word(input logic [31:0] new_w);
        return new_w;
    endfunction
`endif

    always_comb begin
        state_d           = state_q;
        buf_d             = buf_q;
        last_d            = last_q;
        wready            = 1'b1;
        packet_data_valid = 1'b0;
        packet_data_last  = 1'b0;

        case (state_q)
            S_FILL: begin
                if (write_en) begin
`ifdef WRAPPER_PACKET_STROBE_EN
                    buf_d[widx] = merge_word(buf_q[widx], wdata, byte_strobe);
`else
                    buf_d[widx] = merge_word(wdata);
`endif
                    if (hit_last) begin
                        last_d  = last_marker;
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                packet_data_valid = 1'b1;
                packet_data_last  = last_q;
                wready            = packet_data_ready;
                if (packet_data_ready) begin
                    buf_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_FILL;
                    // A write accepted in the handshake cycle starts the next packet.
                    if (write_en) begin
`ifdef WRAPPER_PACKET_STROBE_EN
                        buf_d[widx] = merge_word(32'h0, wdata, byte_strobe);
`else
                        buf_d[widx] = merge_word(wdata);
`endif
                        if (hit_last) begin
                            last_d  = last_marker;
                            state_d = S_FULL;
                        end
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_FILL;
            buf_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
        end
    end

    assign packet_data = buf_q;
    assign rready      = 1'b1;
    assign rdata       = read_en ? buf_q[widx] : 32'h0;

endmodule
